// File: rtl/tl_rx_vc_arbiter_pkg.sv
// Shared constants for the receive-side VC arbiter: FSM encoding, VC indices,
// read-control field layout and beat/entry sizing.
package tl_rx_vc_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    localparam logic [1:0] VC_P   = 2'd0;
    localparam logic [1:0] VC_NP  = 2'd1;
    localparam logic [1:0] VC_CPL = 2'd2;

    localparam int CTRL_HDR_INC      = 4;
    localparam int CTRL_DATA_INC     = 3;
    localparam int CTRL_DATA_VAL_LSB = 0;
    localparam int CTRL_DATA_VAL_W   = 3;

    localparam int BEAT_DW  = 32;
    localparam int ENTRY_DW = 8;

    localparam int HDR_HAS_DATA_BIT = 30;
    localparam int HDR_LEN_W        = 10;

    localparam logic [2:0] ENTRIES_FULL = 3'(BEAT_DW / ENTRY_DW);

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    function automatic logic [1:0] next_vc(input logic [1:0] vc);
        return (vc == VC_CPL) ? VC_P : vc + 2'd1;
    endfunction

    // First eligible buffer scanning from ptr in P -> NP -> CPL order, wrapping.
    function automatic rr_pick_t rr_pick(input logic [2:0] elig, input logic [1:0] ptr);
        rr_pick_t   res;
        logic [1:0] cand;
        res  = '0;
        cand = ptr;
        for (int k = 0; k < 3; k++) begin
            if (!res.found && elig[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
            cand = next_vc(cand);
        end
        return res;
    endfunction

endpackage

// File: rtl/tl_rx_vc_len_decoder.sv
// Header length decode: has-data flag, number of 32-DW beats and the buffer
// entry count consumed by the final beat.
module tl_rx_vc_len_decoder
    import tl_rx_vc_arbiter_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [4*DW-1:0] hdr_i,
    output logic            has_data_o,
    output logic [5:0]      beats_o,
    output logic [2:0]      last_entries_o
);

    localparam int         BEAT_SHIFT  = $clog2(BEAT_DW);
    localparam int         ENTRY_SHIFT = $clog2(ENTRY_DW);
    localparam logic [10:0] BEAT_RND   = 11'(BEAT_DW - 1);
    localparam logic [5:0]  ENTRY_RND  = 6'(ENTRY_DW - 1);

    logic [HDR_LEN_W-1:0] len;
    logic [10:0]          len_full;
    logic [5:0]           rem_full;
    logic                 unused_hdr;

    assign len        = hdr_i[HDR_LEN_W-1:0];
    assign unused_hdr = ^{hdr_i[4*DW-1:HDR_HAS_DATA_BIT+1], hdr_i[HDR_HAS_DATA_BIT-1:HDR_LEN_W]};

    // A zero length field encodes the 1024-DW maximum; a zero remainder is a full beat.
    always_comb begin
        len_full       = (len == '0) ? 11'd1024 : {1'b0, len};
        rem_full       = (len[4:0] == 5'd0) ? 6'(BEAT_DW) : {1'b0, len[4:0]};
        has_data_o     = hdr_i[HDR_HAS_DATA_BIT];
        beats_o        = has_data_o ? 6'((len_full + BEAT_RND) >> BEAT_SHIFT) : 6'd1;
        last_entries_o = 3'((rem_full + ENTRY_RND) >> ENTRY_SHIFT);
    end

endmodule

// File: rtl/tl_rx_vc_arbiter.sv
// Round-robin arbiter over the P/NP/CPL receive buffers; streams the winning TLP
// as 32-DW beats downstream and pulses the selected buffer's read controls.
//   state | meaning
//   IDLE  | pick next eligible buffer from rr pointer, latch its decode
//   XFER  | present beats of the selected TLP until the last one is accepted
module tl_rx_vc_arbiter
    import tl_rx_vc_arbiter_pkg::*;
#(
    parameter int DW               = 32,
    parameter int R_CTRL_BUS_WIDTH = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [2:0]                  i_hdr_empty,
    input  logic [2:0]                  i_data_empty,
    input  logic [4*DW-1:0]             i_tlp_hdr_p,
    input  logic [4*DW-1:0]             i_tlp_hdr_np,
    input  logic [4*DW-1:0]             i_tlp_hdr_cpl,
    input  logic [32*DW-1:0]            i_tlp_data_p,
    input  logic [32*DW-1:0]            i_tlp_data_np,
    input  logic [32*DW-1:0]            i_tlp_data_cpl,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_r_ctrl_bus_p,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_r_ctrl_bus_np,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_r_ctrl_bus_cpl,
    input  logic                        i_np_block,
    output logic                        o_tlp_valid,
    input  logic                        i_tlp_ready,
    output logic                        o_tlp_sop,
    output logic                        o_tlp_eop,
    output logic [1:0]                  o_tlp_sel,
    output logic [4*DW-1:0]             o_tlp_hdr,
    output logic [32*DW-1:0]            o_tlp_data
);

    logic [0:0] state_q, state_d;
    logic [1:0] rr_q, rr_d;
    logic [1:0] sel_q, sel_d;
    logic [5:0] beat_cnt_q, beat_cnt_d;
    logic       first_q, first_d;
    logic       has_data_q, has_data_d;
    logic [2:0] last_entries_q, last_entries_d;

    logic [2:0]                  elig;
    rr_pick_t                    pick;
    logic [4*DW-1:0]             pick_hdr;
    logic                        dec_has_data;
    logic [5:0]                  dec_beats;
    logic [2:0]                  dec_last_entries;
    logic                        xfer;
    logic                        last_beat;
    logic                        hs;
    logic [2:0]                  entries;
    logic [R_CTRL_BUS_WIDTH-1:0] ctrl_sel;

    assign elig = ~i_hdr_empty & {1'b1, ~i_np_block, 1'b1};
    assign pick = rr_pick(elig, rr_q);

    always_comb begin
        case (pick.idx)
            VC_NP:   pick_hdr = i_tlp_hdr_np;
            VC_CPL:  pick_hdr = i_tlp_hdr_cpl;
            default: pick_hdr = i_tlp_hdr_p;
        endcase
    end

    tl_rx_vc_len_decoder #(
        .DW (DW)
    ) u_len_decoder (
        .hdr_i          (pick_hdr),
        .has_data_o     (dec_has_data),
        .beats_o        (dec_beats),
        .last_entries_o (dec_last_entries)
    );

    always_comb begin
        case (sel_q)
            VC_NP: begin
                o_tlp_hdr  = i_tlp_hdr_np;
                o_tlp_data = i_tlp_data_np;
            end
            VC_CPL: begin
                o_tlp_hdr  = i_tlp_hdr_cpl;
                o_tlp_data = i_tlp_data_cpl;
            end
            default: begin
                o_tlp_hdr  = i_tlp_hdr_p;
                o_tlp_data = i_tlp_data_p;
            end
        endcase
    end

    // Reset gates valid so a TLP cut off by reset produces no further increments.
    assign xfer        = (state_q == ST_XFER);
    assign last_beat   = (beat_cnt_q == 6'd1);
    assign o_tlp_valid = xfer && !i_rst && !(has_data_q && i_data_empty[sel_q]);
    assign o_tlp_sop   = xfer && first_q;
    assign o_tlp_eop   = xfer && last_beat;
    assign o_tlp_sel   = sel_q;
    assign hs          = o_tlp_valid && i_tlp_ready;
    assign entries     = last_beat ? last_entries_q : ENTRIES_FULL;

    always_comb begin
        ctrl_sel                                            = '0;
        ctrl_sel[CTRL_HDR_INC]                              = hs && first_q;
        ctrl_sel[CTRL_DATA_INC]                             = hs && has_data_q;
        if (hs && has_data_q) begin
            ctrl_sel[CTRL_DATA_VAL_LSB +: CTRL_DATA_VAL_W]  = entries;
        end
        o_r_ctrl_bus_p   = (sel_q == VC_P)   ? ctrl_sel : '0;
        o_r_ctrl_bus_np  = (sel_q == VC_NP)  ? ctrl_sel : '0;
        o_r_ctrl_bus_cpl = (sel_q == VC_CPL) ? ctrl_sel : '0;
    end

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        sel_d          = sel_q;
        beat_cnt_d     = beat_cnt_q;
        first_d        = first_q;
        has_data_d     = has_data_q;
        last_entries_d = last_entries_q;
        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    state_d        = ST_XFER;
                    sel_d          = pick.idx;
                    has_data_d     = dec_has_data;
                    beat_cnt_d     = dec_beats;
                    last_entries_d = dec_last_entries;
                    first_d        = 1'b1;
                end
            end
            default: begin
                if (hs) begin
                    first_d    = 1'b0;
                    beat_cnt_d = beat_cnt_q - 6'd1;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        rr_d    = next_vc(sel_q);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            rr_q           <= VC_P;
            sel_q          <= VC_P;
            beat_cnt_q     <= '0;
            first_q        <= 1'b0;
            has_data_q     <= 1'b0;
            last_entries_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            sel_q          <= sel_d;
            beat_cnt_q     <= beat_cnt_d;
            first_q        <= first_d;
            has_data_q     <= has_data_d;
            last_entries_q <= last_entries_d;
        end
    end

endmodule

// File: tb/tb_tl_rx_vc_arbiter.sv
// Bench for tl_rx_vc_arbiter: queue-based buffer models feed the DUT, expected
// beats are queued when a TLP is offered and compared as beats are accepted.
module tb_tl_rx_vc_arbiter;
    import tl_rx_vc_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int HW = 4 * DW;
    localparam int PW = 32 * DW;
    localparam int NV = 11;

    typedef struct packed {
        logic [1:0] vc;
        logic       has_data;
        logic [9:0] len;
        logic [5:0] beats;
        logic [2:0] last;
    } vec_t;

    typedef struct packed {
        logic [1:0]    sel;
        logic          sop;
        logic          eop;
        logic          hdr_inc;
        logic          data_inc;
        logic [2:0]    val;
        logic          chk_gap;
        logic [HW-1:0] hdr;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    hdr_empty, data_empty;
    logic [HW-1:0] hdr_p, hdr_np, hdr_cpl, hdr_o;
    logic [PW-1:0] data_p, data_np, data_cpl, data_o;
    logic [RW-1:0] ctrl_p, ctrl_np, ctrl_cpl;
    logic          np_block, valid, ready, sop, eop;
    logic [1:0]    sel;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            last_eop_cyc = 0;
    beat_t         sb[$];
    logic [HW-1:0] hq_p[$], hq_np[$], hq_cpl[$];
    logic [2:0]    pop_flag;
    vec_t          vecs[NV];

    always #5 clk = ~clk;

    tl_rx_vc_arbiter #(
        .DW               (DW),
        .R_CTRL_BUS_WIDTH (RW)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_hdr_empty      (hdr_empty),
        .i_data_empty     (data_empty),
        .i_tlp_hdr_p      (hdr_p),
        .i_tlp_hdr_np     (hdr_np),
        .i_tlp_hdr_cpl    (hdr_cpl),
        .i_tlp_data_p     (data_p),
        .i_tlp_data_np    (data_np),
        .i_tlp_data_cpl   (data_cpl),
        .o_r_ctrl_bus_p   (ctrl_p),
        .o_r_ctrl_bus_np  (ctrl_np),
        .o_r_ctrl_bus_cpl (ctrl_cpl),
        .i_np_block       (np_block),
        .o_tlp_valid      (valid),
        .i_tlp_ready      (ready),
        .o_tlp_sop        (sop),
        .o_tlp_eop        (eop),
        .o_tlp_sel        (sel),
        .o_tlp_hdr        (hdr_o),
        .o_tlp_data       (data_o)
    );

    function automatic logic [PW-1:0] data_pat(input logic [1:0] vc);
        return {32{32'hDA7A_0000 | 32'(vc)}};
    endfunction

    function automatic logic [HW-1:0] make_hdr(input logic has_data, input logic [9:0] len,
                                               input logic [7:0] tag);
        logic [HW-1:0] h;
        h           = '0;
        h[9:0]      = len;
        h[30]       = has_data;
        h[23:16]    = tag;
        h[HW-1 -: 8] = tag;
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_wide(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got low word 0x%08h, expected low word 0x%08h (cycle %0d)",
                     name, act[31:0], exp[31:0], cyc);
        end
    endtask

    task automatic drive_bufs();
        hdr_p        = (hq_p.size() > 0) ? hq_p[0] : '0;
        hdr_np       = (hq_np.size() > 0) ? hq_np[0] : '0;
        hdr_cpl      = (hq_cpl.size() > 0) ? hq_cpl[0] : '0;
        hdr_empty[0] = (hq_p.size() == 0);
        hdr_empty[1] = (hq_np.size() == 0);
        hdr_empty[2] = (hq_cpl.size() == 0);
    endtask

    task automatic push_hdr(input logic [1:0] vc, input logic [HW-1:0] h);
        case (vc)
            VC_NP:   hq_np.push_back(h);
            VC_CPL:  hq_cpl.push_back(h);
            default: hq_p.push_back(h);
        endcase
    endtask

    task automatic monitor();
        logic [2:0][RW-1:0] cb;
        beat_t              e;
        cyc++;
        cb = {ctrl_cpl, ctrl_np, ctrl_p};
        for (int v = 0; v < 3; v++) pop_flag[v] = cb[v][CTRL_HDR_INC];
        if (valid && ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got beat on sel %0d, expected no beat (cycle %0d)", sel, cyc);
            end else begin
                e = sb.pop_front();
                chk("sel", 32'(sel), 32'(e.sel));
                chk("sop", 32'(sop), 32'(e.sop));
                chk("eop", 32'(eop), 32'(e.eop));
                chk("ctrl_sel", 32'(cb[e.sel]), 32'({e.hdr_inc, e.data_inc, e.val}));
                for (int v = 0; v < 3; v++)
                    if (v != int'(e.sel)) chk("ctrl_unsel", 32'(cb[v]), 32'd0);
                if (e.sop) chk_wide("hdr", PW'(hdr_o), PW'(e.hdr));
                if (e.data_inc) chk_wide("data", data_o, data_pat(e.sel));
                if (e.chk_gap && e.sop) chk("bubble_gap", 32'(cyc - last_eop_cyc), 32'd2);
                if (eop) last_eop_cyc = cyc;
            end
        end else begin
            chk("ctrl_no_hs", 32'(cb), 32'd0);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (pop_flag[0] && hq_p.size() > 0) hq_p.delete(0);
        if (pop_flag[1] && hq_np.size() > 0) hq_np.delete(0);
        if (pop_flag[2] && hq_cpl.size() > 0) hq_cpl.delete(0);
        drive_bufs();
    endtask

    task automatic wait_sb(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() > target && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (sb.size() > target) begin
            failures++;
            $display("FAIL %s: timeout with %0d beats outstanding, expected %0d", name, sb.size(), target);
            while (sb.size() > target) sb.delete(0);
        end
    endtask

    task automatic push_exp(input vec_t v, input logic [HW-1:0] h, input logic gap);
        beat_t e;
        for (int b = 0; b < int'(v.beats); b++) begin
            e.sel      = v.vc;
            e.sop      = (b == 0);
            e.eop      = (b == int'(v.beats) - 1);
            e.hdr_inc  = (b == 0);
            e.data_inc = v.has_data;
            e.val      = v.has_data ? (e.eop ? v.last : 3'd4) : 3'd0;
            e.chk_gap  = gap;
            e.hdr      = h;
            sb.push_back(e);
        end
    endtask

    task automatic offer(input vec_t v, input logic [7:0] tag, input logic gap);
        logic [HW-1:0] h;
        h = make_hdr(v.has_data, v.len, tag);
        push_exp(v, h, gap);
        push_hdr(v.vc, h);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_sop"}, 32'(sop), 32'd0);
        chk({tag, "_eop"}, 32'(eop), 32'd0);
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_ctrl"}, 32'({ctrl_cpl, ctrl_np, ctrl_p}), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        sb.delete();
        cycle();
        chk_idle_outputs(tag);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{VC_P,   1'b0, 10'd5,    6'd1,  3'd0};
        vecs[1]  = '{VC_NP,  1'b1, 10'd70,   6'd3,  3'd1};
        vecs[2]  = '{VC_CPL, 1'b1, 10'd0,    6'd32, 3'd4};
        vecs[3]  = '{VC_P,   1'b1, 10'd1,    6'd1,  3'd1};
        vecs[4]  = '{VC_CPL, 1'b1, 10'd32,   6'd1,  3'd4};
        vecs[5]  = '{VC_NP,  1'b1, 10'd33,   6'd2,  3'd1};
        vecs[6]  = '{VC_P,   1'b1, 10'd64,   6'd2,  3'd4};
        vecs[7]  = '{VC_CPL, 1'b1, 10'd17,   6'd1,  3'd3};
        vecs[8]  = '{VC_P,   1'b1, 10'd1023, 6'd32, 3'd4};
        vecs[9]  = '{VC_NP,  1'b1, 10'd9,    6'd1,  3'd2};
        vecs[10] = '{VC_CPL, 1'b0, 10'd0,    6'd1,  3'd0};

        rst        = 1'b1;
        np_block   = 1'b0;
        ready      = 1'b1;
        data_empty = 3'b000;
        data_p     = data_pat(VC_P);
        data_np    = data_pat(VC_NP);
        data_cpl   = data_pat(VC_CPL);
        pop_flag   = '0;
        drive_bufs();
        cycle();
        do_reset("reset");

        for (int i = 0; i < NV; i++) begin
            offer(vecs[i], 8'(i + 1), 1'b0);
            drive_bufs();
            wait_sb(0, 200, "vec_done");
            repeat (2) cycle();
        end

        // Round robin from a fresh pointer, with one bubble between grants.
        do_reset("rr_reset");
        offer('{VC_P,   1'b0, 10'd1, 6'd1, 3'd0}, 8'hA1, 1'b0);
        offer('{VC_NP,  1'b1, 10'd8, 6'd1, 3'd1}, 8'hA2, 1'b1);
        offer('{VC_CPL, 1'b0, 10'd3, 6'd1, 3'd0}, 8'hA3, 1'b1);
        drive_bufs();
        wait_sb(0, 100, "rr_done");
        repeat (2) cycle();

        // NP blocked: P and CPL bypass; NP then runs and survives a re-block mid-TLP.
        do_reset("npb_reset");
        np_block = 1'b1;
        offer('{VC_P, 1'b0, 10'd2, 6'd1, 3'd0}, 8'hB1, 1'b0);
        push_hdr(VC_NP, make_hdr(1'b1, 10'd70, 8'hB2));
        offer('{VC_CPL, 1'b0, 10'd4, 6'd1, 3'd0}, 8'hB3, 1'b1);
        drive_bufs();
        wait_sb(0, 100, "npb_bypass");
        repeat (10) cycle();
        chk("np_waits", 32'(hq_np.size()), 32'd1);
        push_exp('{VC_NP, 1'b1, 10'd70, 6'd3, 3'd1}, make_hdr(1'b1, 10'd70, 8'hB2), 1'b0);
        np_block = 1'b0;
        wait_sb(2, 50, "np_first_beat");
        np_block = 1'b1;
        wait_sb(0, 50, "np_rest");
        chk("np_drained", 32'(hq_np.size()), 32'd0);
        np_block = 1'b0;
        repeat (2) cycle();

        // Data-empty only gates valid; a header-only TLP ignores it.
        offer('{VC_CPL, 1'b1, 10'd40, 6'd2, 3'd1}, 8'hC1, 1'b0);
        drive_bufs();
        wait_sb(1, 50, "cpl_first_beat");
        data_empty = 3'b100;
        repeat (3) begin
            cycle();
            chk("gated_valid", 32'(valid), 32'd0);
        end
        data_empty = 3'b000;
        wait_sb(0, 20, "cpl_done");
        data_empty = 3'b001;
        offer('{VC_P, 1'b0, 10'd7, 6'd1, 3'd0}, 8'hC2, 1'b0);
        drive_bufs();
        wait_sb(0, 20, "hdr_only_ungated");
        data_empty = 3'b000;
        repeat (2) cycle();

        // Backpressure mid-TLP holds the beat, then reset discards the rest.
        do_reset("stall_reset");
        offer('{VC_P, 1'b1, 10'd70, 6'd3, 3'd1}, 8'hD1, 1'b0);
        drive_bufs();
        wait_sb(2, 20, "stall_first_beat");
        ready = 1'b0;
        repeat (5) begin
            cycle();
            chk("stall_valid", 32'(valid), 32'd1);
            chk("stall_sop", 32'(sop), 32'd0);
            chk("stall_eop", 32'(eop), 32'd0);
            chk("stall_sel", 32'(sel), 32'(VC_P));
            chk_wide("stall_data", data_o, data_pat(VC_P));
        end
        chk("stall_no_beat", 32'(sb.size()), 32'd2);
        ready = 1'b1;
        cycle();
        chk("stall_resume", 32'(sb.size()), 32'd1);
        do_reset("mid_reset");
        repeat (3) begin
            cycle();
            chk("post_reset_valid", 32'(valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
